// File: rtl/axis_route_stamp_if.sv
// AXI4-Stream bundle between a vFPGA region, the route-stamp stage and the CEU switch.
// The sink side carries no tdest; the stamp stage is what adds it.
interface axis_route_stamp_if #(
    parameter int DATA_BITS = 32,
    parameter int PID_BITS  = 4
);
    logic                   tvalid;
    logic                   tready;
    logic [DATA_BITS-1:0]   tdata;
    logic [DATA_BITS/8-1:0] tkeep;
    logic                   tlast;
    logic [PID_BITS-1:0]    tid;
    logic [13:0]            tdest;

    modport master (output tvalid, tdata, tkeep, tlast, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tid, output tready);
endinterface

// File: rtl/axis_route_stamp.sv
// Per-region ingress stage: freezes the programmed route for a whole packet, stamps it
// on tdest through a one-deep register slice, and discards packets aimed at a missing port.
//
//   state | meaning
//   IDLE  | between packets; active route follows pending, next beat is a first beat
//   PASS  | forwarding a packet with the route frozen at its first beat
//   DROP  | swallowing the rest of a packet whose port index was out of range
module axis_route_stamp #(
    parameter int N_ID      = 3,
    parameter int DATA_BITS = 32,
    parameter int PID_BITS  = 4
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [13:0]         cfg_route,
    input  logic                cfg_we,
    axis_route_stamp_if.slave   s,
    axis_route_stamp_if.master  m,
    output logic [13:0]         route_active,
    output logic [31:0]         stat_pkts,
    output logic [15:0]         stat_drops
);
    localparam logic [3:0] N_PORTS = 4'(2 * N_ID);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t                 state_q, state_d;
    logic [13:0]            pending_route, active_route, route_sel;
    logic                   route_ok;
    logic                   rdy_en, ready, fire, fwd, drop_first;

    logic                   vld_q, last_q;
    logic [DATA_BITS-1:0]   data_q;
    logic [DATA_BITS/8-1:0] keep_q;
    logic [PID_BITS-1:0]    id_q;
    logic [13:0]            dest_q;

    // pending_route is the registered value, so a same-cycle cfg_we only reaches the next packet
    assign route_sel = (state_q == IDLE) ? pending_route : active_route;
    assign route_ok  = {1'b0, route_sel[5:3]} < N_PORTS;

    always_comb begin
        state_d    = state_q;
        fwd        = 1'b0;
        drop_first = 1'b0;
        ready      = rdy_en & (!vld_q | m.tready);
        if (state_q == DROP) ready = rdy_en;
        fire = s.tvalid & ready;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    if (route_ok) begin
                        fwd = 1'b1;
                        if (!s.tlast) state_d = PASS;
                    end else begin
                        drop_first = 1'b1;
                        if (!s.tlast) state_d = DROP;
                    end
                end
            end
            PASS: begin
                if (fire) begin
                    fwd = 1'b1;
                    if (s.tlast) state_d = IDLE;
                end
            end
            DROP: begin
                if (fire && s.tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= IDLE;
            rdy_en        <= 1'b0;
            pending_route <= '0;
            active_route  <= '0;
            vld_q         <= 1'b0;
            last_q        <= 1'b0;
            data_q        <= '0;
            keep_q        <= '0;
            id_q          <= '0;
            dest_q        <= '0;
            stat_pkts     <= '0;
            stat_drops    <= '0;
        end else begin
            state_q      <= state_d;
            rdy_en       <= 1'b1;
            active_route <= route_sel;
            if (cfg_we) pending_route <= cfg_route;

            if (fwd) begin
                vld_q  <= 1'b1;
                last_q <= s.tlast;
                data_q <= s.tdata;
                keep_q <= s.tkeep;
                id_q   <= s.tid;
                dest_q <= route_sel;
            end else if (m.tready) begin
                vld_q <= 1'b0;
            end

            if (fwd && s.tlast) stat_pkts <= stat_pkts + 32'd1;
            if (drop_first && stat_drops != 16'hFFFF) stat_drops <= stat_drops + 16'd1;
        end
    end

    assign s.tready     = ready;
    assign m.tvalid     = vld_q;
    assign m.tlast      = last_q;
    assign m.tdata      = data_q;
    assign m.tkeep      = keep_q;
    assign m.tid        = id_q;
    assign m.tdest      = dest_q;
    assign route_active = active_route;
endmodule
